z80_io_master: RTL and testbench

CPU-side initiator for Z80 I/O bus cycles (IN/OUT). It takes a single-word request from the core's execution unit, runs the T1/T2/TW/T3 machine cycle on the shared address and data buses, and returns read data with a one-cycle done pulse. It drives IORQ_L, RD_L and WR_L toward the I/O port responders, and honours WAIT_L with a bounded wait-state timeout.

---
 rtl/z80_io_master.sv | 116 +++++++++++
 tb/tb_z80_io_master.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/z80_io_master.sv
// Z80 I/O machine-cycle initiator: runs T1/T2/TW/T3 for IN/OUT requests,
// drives IORQ_L/RD_L/WR_L and the shared buses, and times out stuck WAIT_L.
module z80_io_master #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] port_addr,
  input  logic [7:0]  wdata,
  input  logic        WAIT_L,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  inout  wire  [15:0] addr_bus,
  inout  wire  [7:0]  data_bus
);

  localparam int CW = (MAX_WAIT > 15) ? $clog2(MAX_WAIT + 1) : 4;

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   wcnt, wcnt_nx;
  logic            we_q;
  logic [15:0]     addr_q;
  logic [7:0]      wdata_q;
  logic            addr_oe, data_oe;
  logic            done_nx, err_nx, cap;
  logic            nx_we, nx_busy, nx_strobe;

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    cap      = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_nx = T1;
        wcnt_nx  = '0;
      end
      T1: state_nx = T2;
      T2: state_nx = TW;
      TW: begin
        if (WAIT_L) begin
          state_nx = T3;
        end else if (wcnt == CW'(MAX_WAIT)) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          err_nx   = 1'b1;
        end else begin
          wcnt_nx = wcnt + 1'b1;
        end
      end
      T3: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
        cap      = ~we_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_comb begin
    nx_we     = (state == IDLE) ? we : we_q;
    nx_busy   = (state_nx != IDLE);
    nx_strobe = (state_nx == T2) || (state_nx == TW) || (state_nx == T3);
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state   <= IDLE;
      wcnt    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      addr_oe <= 1'b0;
      data_oe <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      IORQ_L  <= 1'b1;
      RD_L    <= 1'b1;
      WR_L    <= 1'b1;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= port_addr;
        wdata_q <= wdata;
      end
      if (cap) rdata <= data_bus;
      addr_oe <= nx_busy;
      data_oe <= nx_busy && nx_we;
      ready   <= ~nx_busy;
      done    <= done_nx;
      err     <= err_nx;
      IORQ_L  <= ~nx_strobe;
      RD_L    <= ~(nx_strobe && !nx_we);
      WR_L    <= ~(nx_strobe && nx_we);
    end
  end

  assign addr_bus = addr_oe ? addr_q  : 'z;
  assign data_bus = data_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_z80_io_master.sv
// Directed bench for z80_io_master with a 256-port responder whose ports
// power up holding their own address; pulled-up buses reveal release.
module tb_z80_io_master;

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] port_addr = '0;
  logic [7:0]  wdata = '0;
  logic        WAIT_L = 1'b1;
  logic        ready, done, err;
  logic [7:0]  rdata;
  logic        IORQ_L, RD_L, WR_L;
  tri1  [15:0] addr_bus;
  tri1  [7:0]  data_bus;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  mem [256];

  z80_io_master #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_L(rst_L), .req(req), .we(we), .port_addr(port_addr),
    .wdata(wdata), .WAIT_L(WAIT_L), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .addr_bus(addr_bus), .data_bus(data_bus)
  );

  always #5 clk = ~clk;

  assign data_bus = (!IORQ_L && !RD_L) ? mem[addr_bus[7:0]] : 'z;

  always @(posedge clk)
    if (!IORQ_L && !WR_L) mem[addr_bus[7:0]] <= data_bus;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one I/O cycle and checks every cycle up to the done cycle.
  // WAIT_L is low during cycles wf..wt; pre means req was already set up.
  // With chain, req stays high and the next request is loaded in the done cycle.
  task automatic do_io(input string nm, input logic w, input logic [15:0] a,
                       input logic [7:0] d, input int wf, input int wt,
                       input int exp_done, input logic exp_err, input logic pre,
                       input logic chain, input logic nw, input logic [15:0] na,
                       input logic [7:0] nd);
    logic low;
    if (!pre) begin
      req = 1'b1; we = w; port_addr = a; wdata = d;
    end
    @(posedge clk); #1;
    if (!chain) req = 1'b0;
    for (int c = 1; c <= exp_done; c++) begin
      WAIT_L = !(c >= wf && c <= wt);
      low = (c >= 2 && c < exp_done);
      check($sformatf("%s c%0d iorq", nm, c), IORQ_L, !low);
      check($sformatf("%s c%0d rd", nm, c), RD_L, !(low && !w));
      check($sformatf("%s c%0d wr", nm, c), WR_L, !(low && w));
      check($sformatf("%s c%0d addr", nm, c), addr_bus, (c < exp_done) ? a : 16'hFFFF);
      if (w || c == 1 || c == exp_done)
        check($sformatf("%s c%0d data", nm, c), data_bus, (w && c < exp_done) ? d : 8'hFF);
      check($sformatf("%s c%0d done", nm, c), done, c == exp_done);
      check($sformatf("%s c%0d ready", nm, c), ready, c == exp_done);
      if (c == exp_done) check($sformatf("%s err", nm), err, exp_err);
      if (c < exp_done) begin
        @(posedge clk); #1;
      end
    end
    WAIT_L = 1'b1;
    if (chain) begin
      we = nw; port_addr = na; wdata = nd;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset state
    #12;
    check("rst ready", ready, 1'b1);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst rdata", rdata, 8'h00);
    check("rst iorq", IORQ_L, 1'b1);
    check("rst addr", addr_bus, 16'hFFFF);
    check("rst data", data_bus, 8'hFF);
    @(posedge clk); #1; rst_L = 1'b1;
    @(posedge clk); #1;

    // Plain read
    do_io("rd34", 1'b0, 16'h0034, 8'h00, 0, -1, 5, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("rd34 rdata", rdata, 8'h34);
    @(posedge clk); #1;

    // Asynchronous reset in T2 of a write
    req = 1'b1; we = 1'b1; port_addr = 16'h0099; wdata = 8'h11;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    check("mid T2 wr", WR_L, 1'b0);
    #2 rst_L = 1'b0;
    #1;
    check("arst iorq", IORQ_L, 1'b1);
    check("arst wr", WR_L, 1'b1);
    check("arst addr", addr_bus, 16'hFFFF);
    check("arst data", data_bus, 8'hFF);
    check("arst ready", ready, 1'b1);
    check("arst rdata", rdata, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst no done", done, 1'b0);
    end
    rst_L = 1'b1;
    @(posedge clk); #1;
    check("arst no write", mem[8'h99], 8'h99);

    // Write then read back
    do_io("wr12", 1'b1, 16'h0012, 8'h5A, 0, -1, 5, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    do_io("rd12", 1'b0, 16'h0012, 8'h00, 0, -1, 5, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("rd12 rdata", rdata, 8'h5A);
    @(posedge clk); #1;

    // Three extra wait states
    do_io("rd07", 1'b0, 16'h0007, 8'h00, 3, 5, 8, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    check("rd07 rdata", rdata, 8'h07);
    @(posedge clk); #1;

    // Timeout with WAIT_L stuck low
    do_io("tmo", 1'b0, 16'h0050, 8'h00, 3, 1000, 19, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    check("tmo rdata", rdata, 8'h07);
    @(posedge clk); #1;
    check("tmo idle iorq", IORQ_L, 1'b1);
    check("tmo idle done", done, 1'b0);

    // Back-to-back with req held high
    do_io("b2b wr", 1'b1, 16'h00FF, 8'hA5, 0, -1, 5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00FF, 8'h00);
    do_io("b2b rd", 1'b0, 16'h00FF, 8'h00, 0, -1, 5, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("b2b rdata", rdata, 8'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
